// File: rtl/iobus_arbiter_pkg.sv
// Shared types and default widths for the two-master IOBUS arbiter.
package otter_iobus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_LOCK_MAX = 16;

endpackage

// File: rtl/iobus_arbiter_if.sv
// Requester and shared-bus signals of the IOBUS arbiter.
interface iobus_arbiter_if
  import otter_iobus_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  // Handshake: a master raises Mx_REQ with Mx_ADDR/Mx_WDATA/Mx_WR stable and
  // holds them until Mx_ACK, a one-cycle pulse; dropping REQ before the grant
  // withdraws the request and no transaction occurs.
  logic              M0_REQ, M1_REQ;
  logic              M0_WR, M1_WR;
  logic [ADDR_W-1:0] M0_ADDR, M1_ADDR;
  logic [DATA_W-1:0] M0_WDATA, M1_WDATA;
  logic              M1_LOCK;
  logic              M0_ACK, M1_ACK;
  logic [DATA_W-1:0] M0_RDATA, M1_RDATA;
  logic [ADDR_W-1:0] IOBUS_ADDR;
  logic [DATA_W-1:0] IOBUS_OUT;
  logic              IOBUS_WR;
  logic [DATA_W-1:0] IOBUS_IN;

  modport slave (
    input  M0_REQ, M1_REQ, M0_WR, M1_WR, M0_ADDR, M1_ADDR,
           M0_WDATA, M1_WDATA, M1_LOCK, IOBUS_IN,
    output M0_ACK, M1_ACK, M0_RDATA, M1_RDATA, IOBUS_ADDR, IOBUS_OUT, IOBUS_WR
  );

  modport master (
    output M0_REQ, M1_REQ, M0_WR, M1_WR, M0_ADDR, M1_ADDR,
           M0_WDATA, M1_WDATA, M1_LOCK, IOBUS_IN,
    input  M0_ACK, M1_ACK, M0_RDATA, M1_RDATA, IOBUS_ADDR, IOBUS_OUT, IOBUS_WR
  );

endinterface

// File: rtl/iobus_arbiter_rr_pick.sv
// Combinational owner selection: lock hold first, then round-robin on a tie.
module iobus_rr_pick
  import otter_iobus_pkg::*;
(
  input  logic   m0_req,
  input  logic   m1_req,
  input  owner_t last_owner,
  input  logic   lock_hold,
  output logic   gnt_valid,
  output owner_t gnt_owner
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_owner = last_owner;
    if (lock_hold) begin
      gnt_valid = 1'b1;
      gnt_owner = M1;
    end else if (m0_req && m1_req) begin
      gnt_valid = 1'b1;
      gnt_owner = (last_owner == M0) ? M1 : M0;
    end else if (m0_req) begin
      gnt_valid = 1'b1;
      gnt_owner = M0;
    end else if (m1_req) begin
      gnt_valid = 1'b1;
      gnt_owner = M1;
    end
  end

endmodule

// File: rtl/iobus_arbiter.sv
// Two-master IOBUS arbiter: IDLE/XFER/DONE FSM, one bus cycle per transaction.
module iobus_arbiter
  import otter_iobus_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LOCK_MAX = DEF_LOCK_MAX
)(
  input  logic                          CLK,
  input  logic                          RESET_N,
  iobus_arbiter_if.slave                bus,
  output state_t                        dbg_state,
  output owner_t                        dbg_owner,
  output logic [$clog2(LOCK_MAX+1)-1:0] dbg_lock_cnt
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  state_t            state;
  owner_t            owner;
  logic [CNT_W-1:0]  lock_cnt;
  logic              m0_ack, m1_ack;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_out;
  logic              bus_wr;

  logic   arb_phase, lock_hold, elig_m0, elig_m1, gnt_valid;
  owner_t gnt_owner;

  assign arb_phase = (state == IDLE) || (state == DONE);
  // A live lock lets M1 keep the bus straight from DONE, overriding the
  // usual one-cycle ineligibility of the owner that just finished.
  assign lock_hold = arb_phase && (owner == M1) && bus.M1_LOCK && bus.M1_REQ &&
                     (lock_cnt < CNT_W'(LOCK_MAX));
  assign elig_m0   = bus.M0_REQ && !((state == DONE) && (owner == M0));
  assign elig_m1   = bus.M1_REQ && !((state == DONE) && (owner == M1));

  iobus_rr_pick u_pick (
    .m0_req     (elig_m0),
    .m1_req     (elig_m1),
    .last_owner (owner),
    .lock_hold  (lock_hold),
    .gnt_valid  (gnt_valid),
    .gnt_owner  (gnt_owner)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      owner    <= M1;
      lock_cnt <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      bus_addr <= '0;
      bus_out  <= '0;
      bus_wr   <= 1'b0;
    end else begin
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      bus_addr <= '0;
      bus_out  <= '0;
      bus_wr   <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (gnt_valid) begin
            state <= XFER;
            owner <= gnt_owner;
            if (gnt_owner == M0) begin
              bus_addr <= bus.M0_ADDR;
              bus_out  <= bus.M0_WDATA;
              bus_wr   <= bus.M0_WR;
            end else begin
              bus_addr <= bus.M1_ADDR;
              bus_out  <= bus.M1_WDATA;
              bus_wr   <= bus.M1_WR;
            end
          end else begin
            state <= IDLE;
          end
          if (lock_hold) begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end else if (!bus.M1_LOCK || (gnt_valid && (gnt_owner == M0))) begin
            lock_cnt <= '0;
          end
        end
        XFER: begin
          state <= DONE;
          // bus_wr still holds the owner's WR during XFER
          if (owner == M0) begin
            m0_ack <= 1'b1;
            if (!bus_wr) m0_rdata <= bus.IOBUS_IN;
          end else begin
            m1_ack <= 1'b1;
            if (!bus_wr) m1_rdata <= bus.IOBUS_IN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.M0_ACK     = m0_ack;
  assign bus.M1_ACK     = m1_ack;
  assign bus.M0_RDATA   = m0_rdata;
  assign bus.M1_RDATA   = m1_rdata;
  assign bus.IOBUS_ADDR = bus_addr;
  assign bus.IOBUS_OUT  = bus_out;
  assign bus.IOBUS_WR   = bus_wr;
  assign dbg_state      = state;
  assign dbg_owner      = owner;
  assign dbg_lock_cnt   = lock_cnt;

endmodule

// File: tb/tb_iobus_arbiter.sv
// Bench for iobus_arbiter: directed scenarios plus random traffic against a grant-history model.
module tb_iobus_arbiter;
  import otter_iobus_pkg::*;

  localparam int LOCK_MAX = 4;

  // clock / reset
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  iobus_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  state_t     dbg_state;
  owner_t     dbg_owner;
  logic [2:0] dbg_lock_cnt;

  iobus_arbiter #(.DATA_W(32), .ADDR_W(32), .LOCK_MAX(LOCK_MAX)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .bus          (bus),
    .dbg_state    (dbg_state),
    .dbg_owner    (dbg_owner),
    .dbg_lock_cnt (dbg_lock_cnt)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // LED register peripheral at 0x11080001
  logic [15:0] leds = 16'h0;
  always @(posedge CLK)
    if (bus.IOBUS_WR && bus.IOBUS_ADDR == 32'h11080001) leds <= bus.IOBUS_OUT[15:0];

  // Reference model: a transaction is decided at edge t, drives the bus during
  // the following cycle and is acknowledged one cycle later. Arbitration is
  // possible whenever the previous edge made no grant; the master granted two
  // edges ago is the one just finishing and sits out unless it holds the lock.
  logic        m_g1_v = 1'b0, m_g1_o = 1'b0, m_g2_v = 1'b0, m_g2_o = 1'b0;
  logic        m_last = 1'b1;
  int          m_cnt = 0;
  logic [31:0] e_addr = '0, e_out = '0, e_rd0 = '0, e_rd1 = '0;
  logic        e_wr = 1'b0;
  logic [1:0]  e_ack = 2'b00, m_granted = 2'b00;
  logic [1:0]  nxt;
  logic        lock_ok;

  function automatic logic [1:0] arb_pick(input logic r0, input logic r1, input logic ex_v,
                                          input logic ex_o, input logic last, input logic lk);
    logic a0, a1;
    if (lk) return 2'b11;
    a0 = r0 && !(ex_v && ex_o == 1'b0);
    a1 = r1 && !(ex_v && ex_o == 1'b1);
    if (a0 && a1) return {1'b1, ~last};
    if (a0) return 2'b10;
    if (a1) return 2'b11;
    return 2'b00;
  endfunction

  always_comb begin
    lock_ok = m_last && bus.M1_LOCK && bus.M1_REQ && (m_cnt < LOCK_MAX);
    nxt = m_g1_v ? 2'b00 : arb_pick(bus.M0_REQ, bus.M1_REQ, m_g2_v, m_g2_o, m_last, lock_ok);
  end

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_g1_v <= 1'b0; m_g2_v <= 1'b0; m_g1_o <= 1'b0; m_g2_o <= 1'b0;
      m_last <= 1'b1; m_cnt <= 0;
      e_addr <= '0; e_out <= '0; e_wr <= 1'b0; e_ack <= 2'b00;
      e_rd0 <= '0; e_rd1 <= '0; m_granted <= 2'b00;
    end else begin
      e_ack <= 2'b00; e_addr <= '0; e_out <= '0; e_wr <= 1'b0;
      if (!m_g1_v) begin
        if (lock_ok) m_cnt <= m_cnt + 1;
        else if (!bus.M1_LOCK || nxt == 2'b10) m_cnt <= 0;
        if (nxt[1]) begin
          m_last <= nxt[0];
          m_granted[nxt[0]] <= 1'b1;
          e_addr <= nxt[0] ? bus.M1_ADDR  : bus.M0_ADDR;
          e_out  <= nxt[0] ? bus.M1_WDATA : bus.M0_WDATA;
          e_wr   <= nxt[0] ? bus.M1_WR    : bus.M0_WR;
        end
      end else begin
        e_ack[m_g1_o] <= 1'b1;
        m_granted[m_g1_o] <= 1'b0;
        if (!e_wr) begin
          if (m_g1_o) e_rd1 <= bus.IOBUS_IN;
          else        e_rd0 <= bus.IOBUS_IN;
        end
      end
      m_g2_v <= m_g1_v; m_g2_o <= m_g1_o;
      m_g1_v <= nxt[1]; m_g1_o <= nxt[0];
    end
  end

  // every-cycle compare against the model
  always @(negedge CLK) begin
    chk("iobus_addr", 64'(bus.IOBUS_ADDR), 64'(e_addr));
    chk("iobus_out",  64'(bus.IOBUS_OUT),  64'(e_out));
    chk("iobus_wr",   64'(bus.IOBUS_WR),   64'(e_wr));
    chk("m0_ack",     64'(bus.M0_ACK),     64'(e_ack[0]));
    chk("m1_ack",     64'(bus.M1_ACK),     64'(e_ack[1]));
    chk("m0_rdata",   64'(bus.M0_RDATA),   64'(e_rd0));
    chk("m1_rdata",   64'(bus.M1_RDATA),   64'(e_rd1));
    chk("lock_cnt",   64'(dbg_lock_cnt),   64'(m_cnt));
  end

  // scoreboard: expected grant order for the directed sequences
  logic [0:0] exp_q[$];
  logic       sb_en = 1'b0;
  logic [0:0] sb_e;
  always @(negedge CLK) begin
    if (sb_en && dbg_state == XFER && exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      chk("grant_owner", 64'(dbg_owner), 64'(sb_e));
    end
  end

  // driver tasks
  logic [1:0] pend = 2'b00;

  task automatic clear_inputs();
    bus.M0_REQ = 1'b0; bus.M1_REQ = 1'b0; bus.M0_WR = 1'b0; bus.M1_WR = 1'b0;
    bus.M0_ADDR = '0; bus.M1_ADDR = '0; bus.M0_WDATA = '0; bus.M1_WDATA = '0;
    bus.M1_LOCK = 1'b0; bus.IOBUS_IN = '0;
  endtask

  task automatic step_master(input bit m);
    if (pend[m] && e_ack[m]) pend[m] = 1'b0;
    else if (pend[m] && !m_granted[m] && $urandom_range(0, 9) == 0) pend[m] = 1'b0;
    if (!pend[m] && $urandom_range(0, 2) == 0) begin
      pend[m] = 1'b1;
      if (m) begin
        bus.M1_WR = 1'($urandom_range(0, 1)); bus.M1_ADDR = $urandom; bus.M1_WDATA = $urandom;
      end else begin
        bus.M0_WR = 1'($urandom_range(0, 1)); bus.M0_ADDR = $urandom; bus.M0_WDATA = $urandom;
      end
    end
    if (m) bus.M1_REQ = pend[m];
    else   bus.M0_REQ = pend[m];
  endtask

  logic [1:0] t3_tbl [8];
  logic [2:0] peak;

  initial begin
    clear_inputs();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_owner", 64'(dbg_owner), 64'(M1));
    chk("rst_wr",    64'(bus.IOBUS_WR), 64'(0));
    chk("rst_rdata", 64'({bus.M0_RDATA, bus.M1_RDATA}), 64'(0));

    // M0 write to the LED register
    RESET_N = 1'b1;
    bus.M0_REQ = 1'b1; bus.M0_WR = 1'b1;
    bus.M0_ADDR = 32'h11080001; bus.M0_WDATA = 32'h0000A5A5;
    @(negedge CLK);
    chk("t1_bus_wr",   64'(bus.IOBUS_WR), 64'(1));
    chk("t1_bus_addr", 64'(bus.IOBUS_ADDR), 64'h11080001);
    chk("t1_bus_out",  64'(bus.IOBUS_OUT), 64'h0000A5A5);
    chk("t1_state",    64'(dbg_state), 64'(XFER));
    @(negedge CLK);
    chk("t1_m0_ack",   64'(bus.M0_ACK), 64'(1));
    chk("t1_bus_rel",  64'(bus.IOBUS_WR), 64'(0));
    chk("t1_leds",     64'(leds), 64'hA5A5);
    bus.M0_REQ = 1'b0;
    @(negedge CLK);
    chk("t1_ack_pulse", 64'(bus.M0_ACK), 64'(0));

    // M1 read
    bus.M1_REQ = 1'b1; bus.M1_WR = 1'b0; bus.M1_ADDR = 32'h11000000;
    bus.IOBUS_IN = 32'h00001234;
    @(negedge CLK);
    chk("t2_bus_addr", 64'(bus.IOBUS_ADDR), 64'h11000000);
    chk("t2_bus_wr",   64'(bus.IOBUS_WR), 64'(0));
    @(negedge CLK);
    chk("t2_m1_ack",   64'(bus.M1_ACK), 64'(1));
    chk("t2_m1_rdata", 64'(bus.M1_RDATA), 64'h1234);
    chk("t2_m0_rdata", 64'(bus.M0_RDATA), 64'h0);
    chk("t2_m0_ack",   64'(bus.M0_ACK), 64'(0));
    bus.M1_REQ = 1'b0; bus.IOBUS_IN = '0;
    @(negedge CLK);

    // both masters requesting from reset: strict alternation
    RESET_N = 1'b0;
    bus.M0_REQ = 1'b1; bus.M0_WR = 1'b0; bus.M0_ADDR = 32'h100;
    bus.M1_REQ = 1'b1; bus.M1_WR = 1'b1; bus.M1_ADDR = 32'h200; bus.M1_WDATA = 32'h77;
    repeat (2) @(negedge CLK);
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    sb_en = 1'b1;
    t3_tbl = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    RESET_N = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge CLK);
      chk("t3_acks", 64'({bus.M1_ACK, bus.M0_ACK}), 64'(t3_tbl[n]));
    end
    bus.M0_REQ = 1'b0; bus.M1_REQ = 1'b0;
    #1;
    chk("t3_sb_drained", 64'(exp_q.size()), 64'(0));
    sb_en = 1'b0;
    repeat (3) @(negedge CLK);

    // M1 lock run with LOCK_MAX=4
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    bus.M0_REQ = 1'b1; bus.M0_WR = 1'b1; bus.M0_ADDR = 32'h11080001; bus.M0_WDATA = 32'h5A5A;
    repeat (2) @(negedge CLK);
    bus.M0_REQ = 1'b0;
    @(negedge CLK);
    bus.M0_REQ = 1'b1; bus.M0_WR = 1'b0; bus.M0_ADDR = 32'h300;
    bus.M1_REQ = 1'b1; bus.M1_WR = 1'b0; bus.M1_ADDR = 32'h400; bus.M1_LOCK = 1'b1;
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    sb_en = 1'b1;
    peak = 3'd0;
    for (int n = 0; n < 30; n++) begin
      @(negedge CLK);
      #1;
      if (dbg_lock_cnt > peak) peak = dbg_lock_cnt;
      if (exp_q.size() == 0) break;
    end
    chk("t4_sb_drained", 64'(exp_q.size()), 64'(0));
    chk("t4_lock_peak",  64'(peak), 64'(4));
    chk("t4_owner_m0",   64'(dbg_owner), 64'(M0));
    chk("t4_lock_clear", 64'(dbg_lock_cnt), 64'(0));
    sb_en = 1'b0;
    bus.M0_REQ = 1'b0; bus.M1_REQ = 1'b0; bus.M1_LOCK = 1'b0;
    repeat (3) @(negedge CLK);

    // reset while an M0 write is on the bus
    bus.M0_REQ = 1'b1; bus.M0_WR = 1'b1; bus.M0_ADDR = 32'h11080001; bus.M0_WDATA = 32'hBEEF;
    @(posedge CLK);
    #1;
    chk("t5_pre_wr", 64'(bus.IOBUS_WR), 64'(1));
    #1;
    RESET_N = 1'b0;
    #1;
    chk("t5_wr_drop", 64'(bus.IOBUS_WR), 64'(0));
    chk("t5_state",   64'(dbg_state), 64'(IDLE));
    bus.M0_REQ = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      chk("t5_no_ack", 64'(bus.M0_ACK), 64'(0));
    end
    RESET_N = 1'b1;
    bus.M0_REQ = 1'b1;
    @(negedge CLK);
    chk("t5_re_wr",  64'(bus.IOBUS_WR), 64'(1));
    chk("t5_re_out", 64'(bus.IOBUS_OUT), 64'hBEEF);
    @(negedge CLK);
    chk("t5_re_ack", 64'(bus.M0_ACK), 64'(1));
    bus.M0_REQ = 1'b0;
    @(negedge CLK);

    // random traffic
    pend = 2'b00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      bus.IOBUS_IN = $urandom;
      if (cyc >= 1500 && cyc < 1503) begin
        RESET_N = 1'b0;
        pend = 2'b00;
        bus.M0_REQ = 1'b0; bus.M1_REQ = 1'b0;
      end else begin
        RESET_N = 1'b1;
        if ($urandom_range(0, 7) == 0) bus.M1_LOCK = ~bus.M1_LOCK;
        step_master(1'b0);
        step_master(1'b1);
      end
    end
    bus.M0_REQ = 1'b0; bus.M1_REQ = 1'b0;
    repeat (4) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/iobus_arbiter.md
IOBUS_ARBITER -- requirements
Module: iobus_arbiter

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, as the IOBUS data width.
REQ-002 The block SHALL take parameter ADDR_W, default 32, as the IOBUS address width.
REQ-003 The block SHALL take parameter LOCK_MAX, default 16, as the maximum number of consecutive locked M1 transactions.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports M0_REQ/M1_REQ, input, 1 bit each: transaction request (M0 = MCU, M1 = programmer/debug).
REQ-007 The block SHALL have ports M0_WR/M1_WR, input, 1 bit each: 1 = write, 0 = read.
REQ-008 The block SHALL have ports M0_ADDR/M1_ADDR, input, ADDR_W each: target address.
REQ-009 The block SHALL have ports M0_WDATA/M1_WDATA, input, DATA_W each: write data.
REQ-010 The block SHALL have port M1_LOCK, input, 1 bit: M1 requests to retain the bus across transactions.
REQ-011 The block SHALL have ports M0_ACK/M1_ACK, output, 1 bit each: one-cycle completion pulse.
REQ-012 The block SHALL have ports M0_RDATA/M1_RDATA, output, DATA_W each: captured read data.
REQ-013 The block SHALL have port IOBUS_ADDR, output, ADDR_W: shared bus address.
REQ-014 The block SHALL have port IOBUS_OUT, output, DATA_W: shared bus write data.
REQ-015 The block SHALL have port IOBUS_WR, output, 1 bit: shared bus write strobe.
REQ-016 The block SHALL have port IOBUS_IN, input, DATA_W: combinational read data from peripherals.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, XFER, DONE.
REQ-018 Arbitration SHALL occur in IDLE and DONE; if any eligible REQ is high, the next state SHALL be XFER with an owner latched, otherwise IDLE.
REQ-019 In DONE, the current owner's REQ SHALL be ineligible; it becomes eligible again in the following IDLE.
REQ-020 Owner selection SHALL be round-robin: on a tie, the master not granted last wins; the last-owner register SHALL reset to M1, so M0 wins the first tie.
REQ-021 Lock: if the last owner was M1, M1_LOCK=1, M1_REQ=1 and lock_cnt < LOCK_MAX, M1 SHALL win regardless of M0_REQ, and lock_cnt SHALL increment.
REQ-022 lock_cnt SHALL clear whenever M0 is granted or M1_LOCK=0 at arbitration; at LOCK_MAX, normal round-robin SHALL apply.
REQ-023 On entry to XFER, the owner's ADDR, WDATA and WR SHALL be registered onto IOBUS_ADDR, IOBUS_OUT and IOBUS_WR for exactly one cycle.
REQ-024 In XFER, IOBUS_IN SHALL be captured into the owner's RDATA register (reads only; on writes, RDATA is held), and the next state SHALL be DONE.
REQ-025 In DONE, the owner's ACK SHALL pulse high for one cycle; the non-owner's ACK and RDATA SHALL stay unchanged.
REQ-026 Latency: REQ sampled at edge N SHALL give bus drive during cycle N+1 and ACK during cycle N+2; peak throughput SHALL be one transaction per 2 cycles.
REQ-027 Outside XFER, IOBUS_ADDR, IOBUS_OUT and IOBUS_WR SHALL be 0.
REQ-028 Requesters SHALL hold ADDR, WDATA and WR stable from REQ assertion until ACK; REQ dropped before grant SHALL be treated as withdrawn, with no transaction.
REQ-029 Simultaneous M0_REQ and M1_REQ in IDLE with no lock SHALL grant the opposite of last owner; the loser SHALL be granted next from DONE if still requesting.

Reset
REQ-030 RESET_N low SHALL asynchronously force: state IDLE, last owner M1, lock_cnt 0, all ACKs 0, both RDATA 0, IOBUS_* 0.
REQ-031 Reset during XFER or DONE SHALL abort the transaction with no ACK issued.
REQ-032 Reset release SHALL be synchronous to CLK; the first arbitration SHALL occur on the first edge after release.

Structure
REQ-033 Package otter_iobus_pkg SHALL hold the state enum (IDLE/XFER/DONE), the owner enum (M0/M1), and default width constants.
REQ-034 Owner selection SHALL be a sub-module iobus_rr_pick (inputs: reqs, last owner, lock qualifier; output: grant valid + owner), purely combinational; the counter and FSM SHALL live in iobus_arbiter.

Verification
REQ-035 The bench SHALL cover: M0 write, ADDR=0x11080001, WDATA=0x0000A5A5 -> IOBUS_WR=1 with those values for one cycle at N+1; M0_ACK at N+2; LEDs register holds 0xA5A5.
REQ-036 The bench SHALL cover: M1 read of 0x11000000 with IOBUS_IN=0x00001234 -> M1_RDATA=0x1234 and M1_ACK pulse at N+2; M0_RDATA unchanged.
REQ-037 The bench SHALL cover: both REQ held high from reset -> grants alternate M0, M1, M0, M1, with ACKs every 2 cycles.
REQ-038 The bench SHALL cover: M1_LOCK=1 with both REQ high and LOCK_MAX=4 -> after the first M1 grant, 4 further M1 grants, then M0 granted, then lock_cnt=0.
REQ-039 The bench SHALL cover: RESET_N low during XFER of an M0 write -> IOBUS_WR=0 immediately, no M0_ACK, state IDLE; after release, M0 re-request completes normally.
